// File: rtl/zbuff_hit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : zbuff_hit_arbiter
// Purpose  : Round-robin serializer of R18 hit bundles onto the R19 z-buffer
//            write port, with a flush FSM that drains pending hits.
// Options  : ZBUFF_HIT_ARBITER_STATS_EN adds fragment/stall counters.
// Revision : 1.0
// ============================================================================
module zbuff_hit_arbiter #(
  parameter int SIGFIG     = 24,
  parameter int RADIX      = 10,
  parameter int AXIS       = 3,
  parameter int COLORS     = 3,
  parameter int MULTI_TEST = 4,
  parameter int LANE_W     = $clog2(MULTI_TEST)
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             in_valid_R18H,
  output logic                                             in_ready_R18H,
  input  logic [MULTI_TEST-1:0][AXIS-1:0][SIGFIG-1:0]      hit_R18S,
  input  logic [MULTI_TEST-1:0]                            hit_valid_R18H,
  input  logic [COLORS-1:0][SIGFIG-1:0]                    color_R18U,
  output logic                                             out_valid_R19H,
  input  logic                                             out_ready_R19H,
  output logic [AXIS-1:0][SIGFIG-1:0]                      out_hit_R19S,
  output logic [COLORS-1:0][SIGFIG-1:0]                    out_color_R19U,
  output logic [LANE_W-1:0]                                out_lane_R19U,
  input  logic                                             flush_req_H,
  output logic                                             flush_done_H,
`ifdef ZBUFF_HIT_ARBITER_STATS_EN
  output logic [31:0]                                      frag_count_U,
  output logic [31:0]                                      stall_count_U,
`endif
  output logic                                             busy_H
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                                   state_q, state_d;
  logic [MULTI_TEST-1:0][AXIS-1:0][SIGFIG-1:0] hit_q;
  logic [COLORS-1:0][SIGFIG-1:0]            color_q;
  logic [MULTI_TEST-1:0]                    pend_q, pend_d;
  logic [LANE_W-1:0]                        rr_q, rr_d;
  logic [LANE_W-1:0]                        lane_sel;
  logic                                     pend_one;
  logic                                     fire_out;
  logic                                     accept;

  // Rotating priority search: first pending lane at or above rr, wrapping.
  always_comb begin
    logic found;
    int   idx;
    lane_sel = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < MULTI_TEST; i++) begin
      idx = (int'(rr_q) + i) % MULTI_TEST;
      if (!found && pend_q[idx]) begin
        found    = 1'b1;
        lane_sel = LANE_W'(idx);
      end
    end
  end

  assign pend_one       = (pend_q != '0) && ((pend_q & (pend_q - MULTI_TEST'(1))) == '0);
  assign out_valid_R19H = |pend_q;
  assign fire_out       = out_valid_R19H & out_ready_R19H;
  assign in_ready_R18H  = (state_q == S_IDLE) & ~flush_req_H &
                          ((pend_q == '0) | (pend_one & out_ready_R19H));
  assign accept         = in_valid_R18H & in_ready_R18H;

  assign out_hit_R19S   = hit_q[lane_sel];
  assign out_color_R19U = color_q;
  assign out_lane_R19U  = lane_sel;
  assign flush_done_H   = (state_q == S_DONE);
  assign busy_H         = (pend_q != '0) | (state_q != S_IDLE);

  // A new bundle's mask replaces the old one outright, even on the last handshake.
  always_comb begin
    pend_d = pend_q;
    rr_d   = rr_q;
    if (fire_out) begin
      pend_d[lane_sel] = 1'b0;
      rr_d = (int'(lane_sel) == MULTI_TEST - 1) ? '0 : lane_sel + 1'b1;
    end
    if (accept) begin
      pend_d = hit_valid_R18H;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (flush_req_H) state_d = S_DRAIN;
      S_DRAIN: if (pend_d == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      rr_q    <= '0;
      hit_q   <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      if (accept) begin
        hit_q   <= hit_R18S;
        color_q <= color_R18U;
      end
    end
  end

`ifdef ZBUFF_HIT_ARBITER_STATS_EN
  logic [31:0] frag_q, stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frag_q  <= '0;
      stall_q <= '0;
    end else if (state_q == S_DONE) begin
      frag_q  <= '0;
      stall_q <= '0;
    end else begin
      if (fire_out && (frag_q != 32'hFFFF_FFFF)) begin
        frag_q <= frag_q + 32'd1;
      end
      if (out_valid_R19H && !out_ready_R19H && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign frag_count_U  = frag_q;
  assign stall_count_U = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_zbuff_hit_arbiter.sv
`default_nettype none
// Directed self-checking bench for zbuff_hit_arbiter (MULTI_TEST=4, SIGFIG=24).
module tb_zbuff_hit_arbiter;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [3:0][2:0][23:0]   hit;
  logic [3:0]              hit_valid;
  logic [2:0][23:0]        color;
  logic                    out_valid;
  logic                    out_ready;
  logic [2:0][23:0]        out_hit;
  logic [2:0][23:0]        out_color;
  logic [1:0]              out_lane;
  logic                    flush_req;
  logic                    flush_done;
  logic                    busy;
`ifdef ZBUFF_HIT_ARBITER_STATS_EN
  logic [31:0]             frag_count;
  logic [31:0]             stall_count;
`endif

  int npass = 0;
  int ntot  = 0;

  zbuff_hit_arbiter #(
    .SIGFIG(24), .RADIX(10), .AXIS(3), .COLORS(3), .MULTI_TEST(4), .LANE_W(2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid_R18H  (in_valid),
    .in_ready_R18H  (in_ready),
    .hit_R18S       (hit),
    .hit_valid_R18H (hit_valid),
    .color_R18U     (color),
    .out_valid_R19H (out_valid),
    .out_ready_R19H (out_ready),
    .out_hit_R19S   (out_hit),
    .out_color_R19U (out_color),
    .out_lane_R19U  (out_lane),
    .flush_req_H    (flush_req),
    .flush_done_H   (flush_done),
`ifdef ZBUFF_HIT_ARBITER_STATS_EN
    .frag_count_U   (frag_count),
    .stall_count_U  (stall_count),
`endif
    .busy_H         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [23:0] hv(int b, int l, int a);
    return 24'((b << 16) | (l << 8) | (a << 4) | 1);
  endfunction

  function automatic logic [23:0] cv(int b, int c);
    return 24'((b << 16) | 24'h00A000 | (c << 4) | 12);
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(int b, logic [3:0] m);
    for (int l = 0; l < 4; l++)
      for (int a = 0; a < 3; a++)
        hit[l][a] = hv(b, l, a);
    for (int c = 0; c < 3; c++) color[c] = cv(b, c);
    hit_valid = m;
    in_valid  = 1'b1;
  endtask

  task automatic frag(int b, int lane);
    logic [2:0][23:0] eh;
    logic [2:0][23:0] ec;
    for (int a = 0; a < 3; a++) eh[a] = hv(b, lane, a);
    for (int c = 0; c < 3; c++) ec[c] = cv(b, c);
    chk($sformatf("b%0d_valid", b), out_valid, 1);
    chk($sformatf("b%0d_lane", b), out_lane, lane);
    chk($sformatf("b%0d_hit", b), out_hit, eh);
    chk($sformatf("b%0d_color", b), out_color, ec);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; hit_valid = '0; hit = '0; color = '0;
    out_ready = 1'b0; flush_req = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_lane", out_lane, 0);
    chk("rst_out_hit", out_hit, 0);
    chk("rst_out_color", out_color, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_in_ready", in_ready, 1);
    #20 rst = 1'b1;
    cyc();

    // Full bundle drains lanes 0..3, next bundle enters without a bubble
    load(1, 4'b1111); out_ready = 1'b1; #1;
    chk("t1_in_ready_idle", in_ready, 1);
    chk("t1_no_valid_yet", out_valid, 0);
    cyc(); in_valid = 1'b0; #1; frag(1, 0); chk("t1_in_ready_busy", in_ready, 0);
    cyc(); #1; frag(1, 1);
    cyc(); #1; frag(1, 2); chk("t1_in_ready_n3", in_ready, 0);
    cyc(); load(2, 4'b1010); #1; frag(1, 3); chk("t1_in_ready_last", in_ready, 1);

    // Round-robin pointer carries across bundles: 1,3 then 0,1
    cyc(); in_valid = 1'b0; #1; frag(2, 1);
    cyc(); load(3, 4'b0011); #1; frag(2, 3); chk("t2_in_ready_last", in_ready, 1);
    cyc(); in_valid = 1'b0; #1; frag(3, 0);
    cyc(); load(4, 4'b0100); #1; frag(3, 1);
    cyc(); load(5, 4'b0110); #1; frag(4, 2); chk("t3_in_ready_pre", in_ready, 1);

    // Stall with rr=3: lane 1 held for three cycles, then lane 2
    cyc(); in_valid = 1'b0; out_ready = 1'b0; #1; frag(5, 1); chk("t3_in_ready_stall", in_ready, 0);
    cyc(); #1; frag(5, 1);
    cyc(); out_ready = 1'b1; #1; frag(5, 1);
    cyc(); #1; frag(5, 2);
    cyc(); #1;
    chk("t3_drained", out_valid, 0);
`ifdef ZBUFF_HIT_ARBITER_STATS_EN
    chk("t3_frag_count", frag_count, 11);
    chk("t3_stall_count", stall_count, 2);
`endif

    // Flush with three fragments pending (rr=3 -> lanes 3,0,1)
    load(6, 4'b1011); #1;
    chk("t4_in_ready_pre", in_ready, 1);
    cyc(); flush_req = 1'b1; #1;
    frag(6, 3); chk("t4_in_ready_req", in_ready, 0); chk("t4_busy_req", busy, 1);
    cyc(); flush_req = 1'b0; #1;
    frag(6, 0); chk("t4_in_ready_d1", in_ready, 0); chk("t4_done_d1", flush_done, 0);
    cyc(); #1;
    frag(6, 1); chk("t4_in_ready_d2", in_ready, 0); chk("t4_done_d2", flush_done, 0);
    cyc(); #1;
    chk("t4_valid_done", out_valid, 0);
    chk("t4_flush_done", flush_done, 1);
    chk("t4_busy_done", busy, 1);
    chk("t4_in_ready_done", in_ready, 0);
`ifdef ZBUFF_HIT_ARBITER_STATS_EN
    chk("t4_frag_count", frag_count, 14);
`endif
    cyc(); in_valid = 1'b0; #1;
    chk("t4_done_once", flush_done, 0);
    chk("t4_busy_after", busy, 0);
    chk("t4_in_ready_after", in_ready, 1);
`ifdef ZBUFF_HIT_ARBITER_STATS_EN
    chk("t4_frag_cleared", frag_count, 0);
    chk("t4_stall_cleared", stall_count, 0);
`endif

    // Asynchronous reset while pend=1100 is stalled (rr=2 -> lane 2 shown)
    load(7, 4'b1100); out_ready = 1'b0; #1;
    chk("t5_in_ready_pre", in_ready, 1);
    cyc(); in_valid = 1'b0; #1;
    frag(7, 2); chk("t5_busy_pre", busy, 1);
    #1 rst = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_lane", out_lane, 0);
    chk("t5_rst_hit", out_hit, 0);
    chk("t5_rst_color", out_color, 0);
    chk("t5_rst_in_ready", in_ready, 1);
`ifdef ZBUFF_HIT_ARBITER_STATS_EN
    chk("t5_rst_stall", stall_count, 0);
`endif
    #1 rst = 1'b1;
    cyc(); out_ready = 1'b1; #1;
    chk("t5_post_valid", out_valid, 0);
    chk("t5_post_in_ready", in_ready, 1);
    chk("t5_post_busy", busy, 0);
    cyc(); #1;
    chk("t5_no_stale", out_valid, 0);

    // Empty bundle then flush: done two cycles after the request is sampled
    load(8, 4'b0000); #1;
    chk("t6_in_ready_pre", in_ready, 1);
    cyc(); in_valid = 1'b0; flush_req = 1'b1; #1;
    chk("t6_empty_valid", out_valid, 0);
    chk("t6_empty_busy", busy, 0);
    chk("t6_in_ready_req", in_ready, 0);
    chk("t6_done_req", flush_done, 0);
    cyc(); flush_req = 1'b0; #1;
    chk("t6_done_c1", flush_done, 0);
    chk("t6_busy_c1", busy, 1);
    chk("t6_valid_c1", out_valid, 0);
    cyc(); #1;
    chk("t6_done_c2", flush_done, 1);
    chk("t6_valid_c2", out_valid, 0);
    cyc(); #1;
    chk("t6_done_c3", flush_done, 0);
    chk("t6_busy_c3", busy, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
`default_nettype wire
